// File: rtl/sha512_msg_ctrl_pkg.sv
// SHA-512/384 message controller: shared types, IVs, round constants
// and the bit-mixing helpers used by the compression core.
package sha512_msg_ctrl_pkg;

   localparam int WORD_W = 64;
   localparam int BLK_W  = 1024;
   localparam int HASH_W = 512;
   localparam int ROUNDS = 80;

   typedef enum logic [1:0] {
      S_FILL,
      S_PAD,
      S_START,
      S_WAIT
   } state_e;

   localparam logic [HASH_W-1:0] IV512 = {
      64'h6a09e667f3bcc908, 64'hbb67ae8584caa73b,
      64'h3c6ef372fe94f82b, 64'ha54ff53a5f1d36f1,
      64'h510e527fade682d1, 64'h9b05688c2b3e6c1f,
      64'h1f83d9abfb41bd6b, 64'h5be0cd19137e2179
   };

   localparam logic [HASH_W-1:0] IV384 = {
      64'hcbbb9d5dc1059ed8, 64'h629a292a367cd507,
      64'h9159015a3070dd17, 64'h152fecd8f70e5939,
      64'h67332667ffc00b31, 64'h8eb44a8768581511,
      64'hdb0c2e0d64f98fa7, 64'h47b5481dbefa4fa4
   };

   localparam logic [WORD_W-1:0] K_TAB [ROUNDS] = '{
      64'h428a2f98d728ae22, 64'h7137449123ef65cd,
      64'hb5c0fbcfec4d3b2f, 64'he9b5dba58189dbbc,
      64'h3956c25bf348b538, 64'h59f111f1b605d019,
      64'h923f82a4af194f9b, 64'hab1c5ed5da6d8118,
      64'hd807aa98a3030242, 64'h12835b0145706fbe,
      64'h243185be4ee4b28c, 64'h550c7dc3d5ffb4e2,
      64'h72be5d74f27b896f, 64'h80deb1fe3b1696b1,
      64'h9bdc06a725c71235, 64'hc19bf174cf692694,
      64'he49b69c19ef14ad2, 64'hefbe4786384f25e3,
      64'h0fc19dc68b8cd5b5, 64'h240ca1cc77ac9c65,
      64'h2de92c6f592b0275, 64'h4a7484aa6ea6e483,
      64'h5cb0a9dcbd41fbd4, 64'h76f988da831153b5,
      64'h983e5152ee66dfab, 64'ha831c66d2db43210,
      64'hb00327c898fb213f, 64'hbf597fc7beef0ee4,
      64'hc6e00bf33da88fc2, 64'hd5a79147930aa725,
      64'h06ca6351e003826f, 64'h142929670a0e6e70,
      64'h27b70a8546d22ffc, 64'h2e1b21385c26c926,
      64'h4d2c6dfc5ac42aed, 64'h53380d139d95b3df,
      64'h650a73548baf63de, 64'h766a0abb3c77b2a8,
      64'h81c2c92e47edaee6, 64'h92722c851482353b,
      64'ha2bfe8a14cf10364, 64'ha81a664bbc423001,
      64'hc24b8b70d0f89791, 64'hc76c51a30654be30,
      64'hd192e819d6ef5218, 64'hd69906245565a910,
      64'hf40e35855771202a, 64'h106aa07032bbd1b8,
      64'h19a4c116b8d2d0c8, 64'h1e376c085141ab53,
      64'h2748774cdf8eeb99, 64'h34b0bcb5e19b48a8,
      64'h391c0cb3c5c95a63, 64'h4ed8aa4ae3418acb,
      64'h5b9cca4f7763e373, 64'h682e6ff3d6b2b8a3,
      64'h748f82ee5defb2fc, 64'h78a5636f43172f60,
      64'h84c87814a1f0ab72, 64'h8cc702081a6439ec,
      64'h90befffa23631e28, 64'ha4506cebde82bde9,
      64'hbef9a3f7b2c67915, 64'hc67178f2e372532b,
      64'hca273eceea26619c, 64'hd186b8c721c0c207,
      64'heada7dd6cde0eb1e, 64'hf57d4f7fee6ed178,
      64'h06f067aa72176fba, 64'h0a637dc5a2c898a6,
      64'h113f9804bef90dae, 64'h1b710b35131c471b,
      64'h28db77f523047d84, 64'h32caab7b40c72493,
      64'h3c9ebe0a15c9bebc, 64'h431d67c49c100d4c,
      64'h4cc5d4becb3e42b6, 64'h597f299cfc657e2a,
      64'h5fcb6fab3ad6faec, 64'h6c44198c4a475817
   };

   function automatic logic [63:0] rotr(
      input logic [63:0] x,
      input int unsigned n
   );
      return (x >> n) | (x << (64 - n));
   endfunction

   function automatic logic [63:0] bsig0(input logic [63:0] x);
      return rotr(x, 28) ^ rotr(x, 34) ^ rotr(x, 39);
   endfunction

   function automatic logic [63:0] bsig1(input logic [63:0] x);
      return rotr(x, 14) ^ rotr(x, 18) ^ rotr(x, 41);
   endfunction

   function automatic logic [63:0] ssig0(input logic [63:0] x);
      return rotr(x, 1) ^ rotr(x, 8) ^ (x >> 7);
   endfunction

   function automatic logic [63:0] ssig1(input logic [63:0] x);
      return rotr(x, 19) ^ rotr(x, 61) ^ (x >> 6);
   endfunction

   // Keep the top n bytes; n<8 appends the 0x80 marker byte.
   function automatic logic [63:0] pad_last(
      input logic [63:0] d,
      input logic [3:0]  n
   );
      logic [63:0] m;
      m = ~(64'hffff_ffff_ffff_ffff >> {n, 3'b000});
      if (n == 4'd8) return d;
      return (d & m) | (64'h80 << (7'd56 - {n, 3'b000}));
   endfunction

endpackage

// File: rtl/sha512_core.sv
// SHA-512 compression core: one round per clock, o_done 82 clocks
// after i_start. i_vin must be held until o_done for the final add.
module sha512_core
   import sha512_msg_ctrl_pkg::*;
(
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_start,
   input  logic [BLK_W-1:0]  i_data,
   input  logic [HASH_W-1:0] i_vin,
   output logic [HASH_W-1:0] o_vout,
   output logic              o_done
);

   logic [63:0]       w_q  [16];
   logic [63:0]       st_q [8];
   logic [6:0]        rnd_q;
   logic              run_q;
   logic              add_q;
   logic              done_q;
   logic [HASH_W-1:0] vout_q;

   logic [63:0] k;
   logic [63:0] t1;
   logic [63:0] t2;
   logic [63:0] w_new;

   always_comb begin
      k = '0;
      if (rnd_q < 7'd80) k = K_TAB[rnd_q];
      t1 = st_q[7] + bsig1(st_q[4])
         + ((st_q[4] & st_q[5]) ^ (~st_q[4] & st_q[6]))
         + k + w_q[0];
      t2 = bsig0(st_q[0])
         + ((st_q[0] & st_q[1]) ^ (st_q[0] & st_q[2])
            ^ (st_q[1] & st_q[2]));
      w_new = ssig1(w_q[14]) + w_q[9] + ssig0(w_q[1]) + w_q[0];
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         run_q  <= 1'b0;
         add_q  <= 1'b0;
         done_q <= 1'b0;
         rnd_q  <= '0;
         vout_q <= '0;
      end else begin
         done_q <= 1'b0;
         if (i_start) begin
            rnd_q <= '0;
            run_q <= 1'b1;
            add_q <= 1'b0;
         end else if (run_q) begin
            rnd_q <= rnd_q + 7'd1;
            if (rnd_q == 7'd79) begin
               run_q <= 1'b0;
               add_q <= 1'b1;
            end
         end else if (add_q) begin
            for (int i = 0; i < 8; i++)
               vout_q[511-64*i -: 64] <= i_vin[511-64*i -: 64] + st_q[i];
            add_q  <= 1'b0;
            done_q <= 1'b1;
         end
      end
   end

   // Sliding 16-word schedule window: w_q[0] is W[t] of the current round.
   always_ff @(posedge i_clk) begin
      if (i_start) begin
         for (int i = 0; i < 16; i++)
            w_q[i] <= i_data[1023-64*i -: 64];
         for (int i = 0; i < 8; i++)
            st_q[i] <= i_vin[511-64*i -: 64];
      end else if (run_q) begin
         for (int i = 0; i < 15; i++)
            w_q[i] <= w_q[i+1];
         w_q[15] <= w_new;
         st_q[0] <= t1 + t2;
         st_q[1] <= st_q[0];
         st_q[2] <= st_q[1];
         st_q[3] <= st_q[2];
         st_q[4] <= st_q[3] + t1;
         st_q[5] <= st_q[4];
         st_q[6] <= st_q[5];
         st_q[7] <= st_q[6];
      end
   end

   assign o_vout = vout_q;
   assign o_done = done_q;

endmodule

// File: rtl/sha512_msg_ctrl.sv
// Message-level SHA-512/384 controller: packs beats into blocks, pads,
// runs the core once per block and chains the intermediate hash.
module sha512_msg_ctrl
   import sha512_msg_ctrl_pkg::*;
#(
   parameter bit P_SHA384 = 1'b0
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic [63:0]       i_data,
   input  logic              i_valid,
   input  logic              i_last,
   input  logic [3:0]        i_bytes,
   output logic              o_ready,
   output logic [HASH_W-1:0] o_hash,
   output logic              o_hash_valid
);

   localparam logic [HASH_W-1:0] IV = P_SHA384 ? IV384 : IV512;

   state_e             state_q, state_d;
   logic [15:0][63:0]  blk_q, blk_d;
   logic [HASH_W-1:0]  cv_q, cv_d;
   logic [127:0]       len_q, len_d;
   logic [3:0]         idx_q, idx_d;
   logic               pend_q, pend_d;
   logic               late_q, late_d;
   logic               eom_q, eom_d;
   logic               fin_q, fin_d;
   logic [HASH_W-1:0]  hash_q, hash_d;
   logic               hv_q, hv_d;

   logic               core_start;
   logic [HASH_W-1:0]  core_vout;
   logic               core_done;

   logic               acc;
   logic [3:0]         nb;
   logic               len_ok;
   logic [63:0]        word;

   assign o_ready = (state_q == S_FILL) && !hv_q && !i_rst;

   always_comb begin
      state_d    = state_q;
      blk_d      = blk_q;
      cv_d       = cv_q;
      len_d      = len_q;
      idx_d      = idx_q;
      pend_d     = pend_q;
      late_d     = late_q;
      eom_d      = eom_q;
      fin_d      = fin_q;
      hash_d     = hash_q;
      hv_d       = 1'b0;
      core_start = 1'b0;
      acc        = i_valid && o_ready;
      nb         = (i_bytes > 4'd8) ? 4'd8 : i_bytes;
      len_ok     = !pend_q && !late_q;
      word       = pend_q ? 64'h8000_0000_0000_0000 : 64'h0;

      unique case (state_q)
         S_FILL: begin
            if (acc) begin
               idx_d = idx_q + 4'd1;
               if (!i_last) begin
                  blk_d[~idx_q] = i_data;
                  len_d = len_q + 128'd64;
                  if (idx_q == 4'd15) begin
                     fin_d   = 1'b0;
                     state_d = S_START;
                  end
               end else begin
                  blk_d[~idx_q] = pad_last(i_data, nb);
                  len_d  = len_q + {121'b0, nb, 3'b000};
                  pend_d = (nb == 4'd8);
                  late_d = (nb != 4'd8) && (idx_q > 4'd13);
                  eom_d  = 1'b1;
                  fin_d  = 1'b0;
                  // A last beat that fills the block leaves padding owed.
                  state_d = (idx_q == 4'd15) ? S_START : S_PAD;
               end
            end
         end
         S_PAD: begin
            idx_d = idx_q + 4'd1;
            if (idx_q == 4'd14 && len_ok) word = len_q[127:64];
            if (idx_q == 4'd15 && len_ok) word = len_q[63:0];
            if (pend_q) begin
               pend_d = 1'b0;
               late_d = (idx_q > 4'd13);
            end
            blk_d[~idx_q] = word;
            if (idx_q == 4'd15) begin
               fin_d   = len_ok;
               state_d = S_START;
            end
         end
         S_START: begin
            core_start = 1'b1;
            state_d    = S_WAIT;
         end
         S_WAIT: begin
            if (core_done) begin
               cv_d  = core_vout;
               idx_d = '0;
               if (fin_q) begin
                  hash_d  = P_SHA384 ? {core_vout[511:128], 128'b0}
                                     : core_vout;
                  hv_d    = 1'b1;
                  cv_d    = IV;
                  len_d   = '0;
                  eom_d   = 1'b0;
                  late_d  = 1'b0;
                  pend_d  = 1'b0;
                  state_d = S_FILL;
               end else if (eom_q) begin
                  late_d  = 1'b0;
                  state_d = S_PAD;
               end else begin
                  state_d = S_FILL;
               end
            end
         end
         default: state_d = S_FILL;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q <= S_FILL;
         blk_q   <= '0;
         cv_q    <= IV;
         len_q   <= '0;
         idx_q   <= '0;
         pend_q  <= 1'b0;
         late_q  <= 1'b0;
         eom_q   <= 1'b0;
         fin_q   <= 1'b0;
         hash_q  <= '0;
         hv_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         blk_q   <= blk_d;
         cv_q    <= cv_d;
         len_q   <= len_d;
         idx_q   <= idx_d;
         pend_q  <= pend_d;
         late_q  <= late_d;
         eom_q   <= eom_d;
         fin_q   <= fin_d;
         hash_q  <= hash_d;
         hv_q    <= hv_d;
      end
   end

   sha512_core u_core (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_start (core_start),
      .i_data  (blk_q),
      .i_vin   (cv_q),
      .o_vout  (core_vout),
      .o_done  (core_done)
   );

   assign o_hash       = hash_q;
   assign o_hash_valid = hv_q;

endmodule
